// File: rtl/ula_arb_ctrl_if.sv
// Request, ULA and response signals between the two clients, the ULA and ula_arb_ctrl.
interface ula_arb_ctrl_if;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b, req0_s;
    logic       req0_m, req0_cin;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b, req1_s;
    logic       req1_m, req1_cin;
    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic       alu_m, alu_cin, alu_eq;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_eq;
    logic [3:0] rsp_f;

    modport master (
        output req0_valid, req0_a, req0_b, req0_s, req0_m, req0_cin,
        output req1_valid, req1_a, req1_b, req1_s, req1_m, req1_cin,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_cin,
        output alu_f, alu_eq,
        input  rsp_valid, rsp_id, rsp_f, rsp_eq,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s, req0_m, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_s, req1_m, req1_cin,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_cin,
        input  alu_f, alu_eq,
        output rsp_valid, rsp_id, rsp_f, rsp_eq,
        input  rsp_ready
    );
endinterface

// File: rtl/ula_arb_ctrl.sv
// Round-robin two-client sequencer for one shared 4-bit ULA with a settle-and-capture response.
// Define ULA_ARB_STATS_EN to add the saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module ula_arb_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    ula_arb_ctrl_if.slave bus
`ifdef ULA_ARB_STATS_EN
    ,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state;
    logic       last;
    logic [3:0] cnt;
    logic       grant0, grant1, hs0, hs1;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
    end

    assign bus.req0_ready = (state == IDLE) & grant0 & ~rst;
    assign bus.req1_ready = (state == IDLE) & grant1 & ~rst;
    assign hs0 = bus.req0_valid & bus.req0_ready;
    assign hs1 = bus.req1_valid & bus.req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last          <= 1'b1;
            cnt           <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_s     <= '0;
            bus.alu_m     <= 1'b0;
            bus.alu_cin   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_f     <= '0;
            bus.rsp_eq    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 | hs1) begin
                        bus.alu_a   <= hs1 ? bus.req1_a   : bus.req0_a;
                        bus.alu_b   <= hs1 ? bus.req1_b   : bus.req0_b;
                        bus.alu_s   <= hs1 ? bus.req1_s   : bus.req0_s;
                        bus.alu_m   <= hs1 ? bus.req1_m   : bus.req0_m;
                        bus.alu_cin <= hs1 ? bus.req1_cin : bus.req0_cin;
                        bus.rsp_id  <= hs1;
                        last        <= hs1;
                        cnt         <= 4'(SETTLE_CYCLES);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == 4'd1) begin
                        bus.rsp_f     <= bus.alu_f;
                        bus.rsp_eq    <= bus.alu_eq;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ULA_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (hs0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (hs1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ula_arb_ctrl.sv
// Scoreboard bench for ula_arb_ctrl with a behavioural ULA on each instance.
module tb_ula_arb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ula_arb_ctrl_if ifc();
    ula_arb_ctrl_if ifc3();

`ifdef ULA_ARB_STATS_EN
    logic [15:0] gc0, gc1, gc30, gc31;
    ula_arb_ctrl #(.SETTLE_CYCLES(1)) dut  (.clk(clk), .rst(rst), .bus(ifc),  .gnt_cnt0(gc0),  .gnt_cnt1(gc1));
    ula_arb_ctrl #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3), .gnt_cnt0(gc30), .gnt_cnt1(gc31));
`else
    ula_arb_ctrl #(.SETTLE_CYCLES(1)) dut  (.clk(clk), .rst(rst), .bus(ifc));
    ula_arb_ctrl #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3));
`endif

    // Bench ULA: s=0 is AND in logic mode and A+B+cin in arithmetic mode.
    function automatic logic [4:0] ula(input logic [3:0] a, b, s, input logic m, cin);
        logic [3:0] f;
        if (m) begin
            case (s)
                4'h0:    f = a & b;
                4'h1:    f = a | b;
                4'h2:    f = a ^ b;
                default: f = ~a;
            endcase
        end else begin
            case (s)
                4'h1:    f = a - b;
                default: f = a + b + {3'b000, cin};
            endcase
        end
        return {a == b, f};
    endfunction

    assign {ifc.alu_eq, ifc.alu_f}   = ula(ifc.alu_a, ifc.alu_b, ifc.alu_s, ifc.alu_m, ifc.alu_cin);
    assign {ifc3.alu_eq, ifc3.alu_f} = ula(ifc3.alu_a, ifc3.alu_b, ifc3.alu_s, ifc3.alu_m, ifc3.alu_cin);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {logic id; logic eq; logic [3:0] f;} exp_t;
    exp_t sb[$];
    int   gq[$];
    int   cyc = 0, hs_cyc = 0, rsp_cyc = 0;
    int   hs_n[2];
    exp_t e;

    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            chk("one_ready", {31'b0, ifc.req0_ready & ifc.req1_ready}, 0);
            if (ifc.req0_valid && ifc.req0_ready) begin
                sb.push_back({1'b0, ula(ifc.req0_a, ifc.req0_b, ifc.req0_s, ifc.req0_m, ifc.req0_cin)});
                gq.push_back(0);
                hs_n[0]++;
                hs_cyc = cyc;
            end
            if (ifc.req1_valid && ifc.req1_ready) begin
                sb.push_back({1'b1, ula(ifc.req1_a, ifc.req1_b, ifc.req1_s, ifc.req1_m, ifc.req1_cin)});
                gq.push_back(1);
                hs_n[1]++;
                hs_cyc = cyc;
            end
            if (ifc.rsp_valid && ifc.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", {31'b0, ifc.rsp_id}, {31'b0, e.id});
                    chk("rsp_f",  {28'b0, ifc.rsp_f},  {28'b0, e.f});
                    chk("rsp_eq", {31'b0, ifc.rsp_eq}, {31'b0, e.eq});
                end
                rsp_cyc = cyc;
            end
        end
        cyc++;
    end

    // Called at a negedge; returns at the negedge after the handshake with valid dropped.
    task automatic req(input int id, input logic [3:0] a, b, s, input logic m, cin);
        int start = hs_n[id];
        int n = 0;
        if (id == 0) begin
            ifc.req0_a = a; ifc.req0_b = b; ifc.req0_s = s; ifc.req0_m = m; ifc.req0_cin = cin;
            ifc.req0_valid = 1'b1;
        end else begin
            ifc.req1_a = a; ifc.req1_b = b; ifc.req1_s = s; ifc.req1_m = m; ifc.req1_cin = cin;
            ifc.req1_valid = 1'b1;
        end
        while (hs_n[id] == start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (hs_n[id] == start) chk("hs_timeout", 0, 1);
        if (id == 0) ifc.req0_valid = 1'b0;
        else         ifc.req1_valid = 1'b0;
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!ifc.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || ifc.rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {31'b0, n < 200}, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        hs_n[0] = 0; hs_n[1] = 0;
        {ifc.req0_valid, ifc.req0_a, ifc.req0_b, ifc.req0_s, ifc.req0_m, ifc.req0_cin} = '0;
        {ifc.req1_valid, ifc.req1_a, ifc.req1_b, ifc.req1_s, ifc.req1_m, ifc.req1_cin} = '0;
        {ifc3.req0_valid, ifc3.req0_a, ifc3.req0_b, ifc3.req0_s, ifc3.req0_m, ifc3.req0_cin} = '0;
        {ifc3.req1_valid, ifc3.req1_a, ifc3.req1_b, ifc3.req1_s, ifc3.req1_m, ifc3.req1_cin} = '0;
        ifc.rsp_ready = 1'b1;
        ifc3.rsp_ready = 1'b1;

        // Reset state, with a request pending that must not be accepted.
        ifc.req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready0", {31'b0, ifc.req0_ready}, 0);
        chk("rst_rsp_valid", {31'b0, ifc.rsp_valid}, 0);
        chk("rst_alu", {19'b0, ifc.alu_a, ifc.alu_b, ifc.alu_s, ifc.alu_m}, 0);
        chk("rst_rsp_f", {28'b0, ifc.rsp_f}, 0);
        ifc.req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single request: AND, latency SETTLE+1.
        req(0, 4'hC, 4'hA, 4'h0, 1'b1, 1'b0);
        wait_rv();
        chk("lat_s1", cyc - hs_cyc, 2);
        chk("and_f", {28'b0, ifc.rsp_f}, 32'h8);
        chk("and_id", {31'b0, ifc.rsp_id}, 0);
        wait_idle();

        // Arithmetic wrap and equality.
        req(1, 4'h9, 4'h8, 4'h0, 1'b0, 1'b0);
        wait_rv();
        chk("wrap_f", {28'b0, ifc.rsp_f}, 32'h1);
        chk("wrap_id", {31'b0, ifc.rsp_id}, 1);
        wait_idle();
        req(0, 4'h5, 4'h5, 4'h2, 1'b1, 1'b0);
        wait_rv();
        chk("eq", {31'b0, ifc.rsp_eq}, 1);
        wait_idle();

        // Contention from reset: grants alternate starting with req0.
        pulse_rst();
        gq.delete();
        fork
            begin req(0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0); req(0, 4'h3, 4'h3, 4'h1, 1'b1, 1'b0); end
            begin req(1, 4'h7, 4'h2, 4'h1, 1'b0, 1'b0); req(1, 4'h4, 4'h6, 4'h2, 1'b1, 1'b0); end
        join
        wait_idle();
        chk("gnt_count", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("gnt_order", gq[i], i % 2);

        // Backpressure: response held, no request accepted, next handshake one cycle after accept.
        ifc.rsp_ready = 1'b0;
        req(0, 4'h6, 4'h3, 4'h0, 1'b0, 1'b1);
        fork
            req(1, 4'h2, 4'h2, 4'h0, 1'b1, 1'b0);
            begin
                wait_rv();
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", {31'b0, ifc.rsp_valid}, 1);
                    chk("bp_f", {28'b0, ifc.rsp_f}, 32'hA);
                    chk("bp_id", {31'b0, ifc.rsp_id}, 0);
                    chk("bp_ready1", {31'b0, ifc.req1_ready}, 0);
                end
                ifc.rsp_ready = 1'b1;
            end
        join
        chk("bp_next_hs", hs_cyc - rsp_cyc, 1);
        wait_idle();

        // Reset during ISSUE: no response, outputs at reset values, req0 wins the next tie.
        req(0, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        pulse_rst();
        chk("mid_rsp_valid", {31'b0, ifc.rsp_valid}, 0);
        chk("mid_alu", {19'b0, ifc.alu_a, ifc.alu_b, ifc.alu_s, ifc.alu_m}, 0);
        chk("mid_rsp", {27'b0, ifc.rsp_id, ifc.rsp_f}, 0);
        gq.delete();
        fork
            req(0, 4'h2, 4'h3, 4'h1, 1'b1, 1'b0);
            req(1, 4'hF, 4'h1, 4'h0, 1'b0, 1'b1);
        join
        wait_idle();
        chk("mid_tie", gq.size() > 0 ? gq[0] : 9, 0);

        // SETTLE_CYCLES=3 instance: first rsp_valid four cycles after the handshake.
        begin
            int n;
            ifc3.req0_a = 4'h3; ifc3.req0_b = 4'h4; ifc3.req0_s = 4'h0;
            ifc3.req0_m = 1'b0; ifc3.req0_cin = 1'b0; ifc3.req0_valid = 1'b1;
            #1;
            chk("s3_ready", {31'b0, ifc3.req0_ready}, 1);
            @(negedge clk);
            ifc3.req0_valid = 1'b0;
            n = 1;
            while (!ifc3.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("s3_lat", n, 4);
            chk("s3_f", {28'b0, ifc3.rsp_f}, 32'h7);
            @(negedge clk);
        end

`ifdef ULA_ARB_STATS_EN
        pulse_rst();
        req(0, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        req(1, 4'h2, 4'h1, 4'h0, 1'b0, 1'b0);
        req(0, 4'h3, 4'h1, 4'h0, 1'b0, 1'b0);
        req(1, 4'h4, 4'h1, 4'h0, 1'b0, 1'b0);
        req(0, 4'h5, 4'h1, 4'h0, 1'b0, 1'b0);
        wait_idle();
        chk("gnt_cnt0", {16'b0, gc0}, 3);
        chk("gnt_cnt1", {16'b0, gc1}, 2);
        pulse_rst();
        chk("gnt_cnt_rst", {gc0, gc1}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ula_arb_ctrl.md
# ula_arb_ctrl

Two-requester arbiter and sequencer that shares one 4-bit ULA (74181-style ALU: ports a, b, s, m, c_in, f, a_eq_b) between two clients. Each client submits one operation per valid/ready handshake. The controller arbitrates round-robin and drives the ULA operand/control inputs from registers. It holds them for a configurable settle time, captures f/a_eq_b, and returns a tagged response through a valid/ready response port with backpressure. It sits between the ULA instance and the datapath blocks that need ALU service.

## Interface
- SETTLE_CYCLES, default 1: cycles operands are held on the ULA before capture; legal range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N=0,1) request N has an operation pending.
- reqN_ready  out  1  request N accepted this cycle (valid & ready = handshake).
- reqN_a, reqN_b  in  4 each  operands.
- reqN_s  in  4  ULA function select.
- reqN_m  in  1  ULA mode (1 logic, 0 arithmetic).
- reqN_cin  in  1  ULA carry-in.
- alu_a, alu_b  out  4 each  to ULA a, b.
- alu_s  out  4  to ULA s.
- alu_m  out  1  to ULA m.
- alu_cin  out  1  to ULA c_in.
- alu_f  in  4  from ULA f.
- alu_eq  in  1  from ULA a_eq_b.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index that issued the operation.
- rsp_f  out  4  captured result.
- rsp_eq  out  1  captured a_eq_b.
- gnt_cnt0, gnt_cnt1  out  16 each  grant counters (only with ULA_ARB_STATS_EN).

## Operation
- FSM states:
  - IDLE: reqN_ready = (state==IDLE) & grantN. Handshake latches operands, s, m, cin and id into registers, loads settle counter = SETTLE_CYCLES, goes to ISSUE.
  - ISSUE: alu_* driven from registers; counter decrements each cycle. In the cycle the counter equals 1, alu_f/alu_eq are captured into rsp_f/rsp_eq and the FSM goes to RESP.
  - RESP: rsp_valid=1; rsp_id/f/eq stable until rsp_valid & rsp_ready, then IDLE.
- Arbitration is combinational in IDLE only:
  - Single valid requester wins.
  - Both valid: the requester not granted last wins.
  - The last-grant pointer updates only on a handshake.
- At most one reqN_ready high per cycle; both are 0 outside IDLE.
- alu_* hold the last issued values in IDLE and RESP (no toggling when idle).
- Requester inputs are ignored unless handshaking; changing them while valid and not ready is legal, and the accepted value is the one present on the handshake cycle.
- The controller adds no arithmetic: result width and wrap-around are exactly those of the ULA output (4 bits).

## Timing
- Reset values: state IDLE; alu_a/b/s=0, alu_m=0, alu_cin=0; rsp_valid=0, rsp_id=0, rsp_f=0, rsp_eq=0; last-grant pointer=1 (req0 wins the first tie); reqN_ready=0 during reset.
- Latency:
  - Handshake at edge T gives ISSUE cycles T+1..T+SETTLE_CYCLES.
  - rsp_valid is first high in cycle T+SETTLE_CYCLES+1.
- Throughput: one operation per SETTLE_CYCLES+2 cycles when rsp_ready is held high. A response accepted at edge U allows a new handshake at the earliest at edge U+1.
- rsp_ready low holds RESP indefinitely; no request is accepted meanwhile.
- rst asserted in any state: next cycle is IDLE with reset values. In-flight operation and pending response are discarded; no response is emitted for them.

## Configuration
- ULA_ARB_STATS_EN defined:
  - gnt_cnt0/gnt_cnt1 exist.
  - Each increments by 1 on its requester's handshake, saturates at 0xFFFF and resets to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Single request, bench ULA model, SETTLE_CYCLES=1: req0 a=0xC b=0xA s=0000 m=1 handshake at edge T → rsp_valid in cycle T+2 with rsp_f=0x8, rsp_id=0, rsp_eq=0.
- Arithmetic wrap: req1 a=0x9 b=0x8 s=0000 m=0 → rsp_f=0x1, rsp_id=1. Equality: a=0x5 b=0x5 → rsp_eq=1.
- Contention: both valid continuously from reset with distinct operands → grants alternate 0,1,0,1. rsp_id follows the same sequence, and each rsp_f matches that requester's operands.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_f and rsp_id stable; req0/1_ready stay 0. Raise rsp_ready → IDLE next cycle, next handshake one cycle after acceptance.
- Reset mid-operation: assert rst during ISSUE → next cycle IDLE, all outputs at reset values, no rsp_valid. The following tie is granted to req0.
- SETTLE_CYCLES=3 plus ULA_ARB_STATS_EN: rsp_valid is first high 4 cycles after the handshake. After 3 req0 and 2 req1 grants, gnt_cnt0=3 and gnt_cnt1=2; the counters return to 0 on rst.
